// File: rtl/sm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm_pkg: shared types and helpers for the sign-magnitude serial encoder.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sm_pkg;

    localparam int SM_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sm_state_e;

    // Never returns 0 so a counter declared from it always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_neg_bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_neg_bit: one bit per clock of copy-until-first-one-then-invert.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module serial_neg_bit (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic sign_i,
    input  logic bit_i,
    output logic out_bit_o
);

    logic seen_q;
    logic seen_d;

    always_comb begin
        out_bit_o = bit_i ^ (sign_i & seen_q);
        seen_d    = seen_q;
        if (clr_i) begin
            seen_d = 1'b0;
        end else if (en_i) begin
            seen_d = seen_q | bit_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_encode_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sm_encode_serial: bit-serial two's-complement to sign-magnitude encoder. |
// | Define SM_ENCODE_SAT_EN to saturate -2^(W-1) to {1,all ones} with Ovf.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sm_encode_serial
    import sm_pkg::*;
#(
    parameter int W = SM_W
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] DataIn,
    input  logic         InValid,
    output logic         InReady,
    output logic [W-1:0] DataOut,
    output logic         OutValid,
    input  logic         OutReady,
    output logic         Ovf
);

    localparam int CW = clog2(W - 1);

    sm_state_e     state_q;
    sm_state_e     state_d;
    logic [W-2:0]  shreg_q;
    logic [W-2:0]  mag_q;
    logic          sign_q;
    logic [CW-1:0] count_q;

    logic          w_accept;
    logic          w_shift;
    logic          w_last;
    logic          w_out_bit;

    assign w_accept = (state_q == IDLE) && InValid;
    assign w_shift  = (state_q == SHIFT);
    assign w_last   = w_shift && (count_q == CW'(W - 2));

    serial_neg_bit u_neg (
        .clk_i     (Clock),
        .rst_i     (Reset),
        .clr_i     (w_accept),
        .en_i      (w_shift),
        .sign_i    (sign_q),
        .bit_i     (shreg_q[count_q]),
        .out_bit_o (w_out_bit)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (InValid)  state_d = SHIFT;
            SHIFT:   if (w_last)   state_d = DONE;
            DONE:    if (OutReady) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Minimum negative is the only input whose magnitude comes out all zeros
    // with the sign set, so it is recognised from the held result in DONE.
    always_comb begin
        InReady  = (state_q == IDLE);
        OutValid = (state_q == DONE);
        DataOut  = '0;
        Ovf      = 1'b0;
        if (state_q == DONE) begin
`ifdef SM_ENCODE_SAT_EN
            if (sign_q && (mag_q == '0)) begin
                DataOut = '1;
                Ovf     = 1'b1;
            end else begin
                DataOut = {sign_q, mag_q};
            end
`else
            DataOut = {sign_q, mag_q};
`endif
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            shreg_q <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
        end else if (w_accept) begin
            shreg_q <= DataIn[W-2:0];
            mag_q   <= '0;
            sign_q  <= DataIn[W-1];
            count_q <= '0;
        end else if (w_shift) begin
            mag_q[count_q] <= w_out_bit;
            count_q        <= count_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_encode_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sm_encode_serial: scoreboard bench for sm_encode_serial (W=8).        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sm_encode_serial;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic [W-1:0] DataIn = '0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] DataOut;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic         Ovf;

    int           n_vec = 0;
    int           n_err = 0;
    int           rdy_mode = 1;
    bit           chk_period = 1'b0;
    longint       last_acc_t = 0;
    logic [8:0]   exp_q[$];
    logic [8:0]   mon_e;

    sm_encode_serial #(.W(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DataIn   (DataIn),
        .InValid  (InValid),
        .InReady  (InReady),
        .DataOut  (DataOut),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Ovf      (Ovf)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: sign-magnitude of the signed value; returns {ovf, data}.
    function automatic logic [8:0] model(input logic [7:0] x);
        int v;
        v = int'($signed(x));
        if (v == -128) begin
`ifdef SM_ENCODE_SAT_EN
            return {1'b1, 8'hFF};
`else
            return {1'b0, 8'h80};
`endif
        end
        if (v < 0) return {2'b01, 7'(-v)};
        return {2'b00, 7'(v)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clock) begin
        #2;
        case (rdy_mode)
            0:       OutReady = 1'b0;
            1:       OutReady = 1'b1;
            default: OutReady = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge Clock) begin
        if (!Reset && OutValid && OutReady) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", int'(DataOut), -1);
            end else begin
                mon_e = exp_q.pop_front();
                check("data", int'(DataOut), int'(mon_e[7:0]));
                check("ovf", int'(Ovf), int'(mon_e[8]));
            end
        end
    end

    task automatic send(input logic [7:0] v, input bit push);
        int t;
        t = 0;
        do begin
            @(posedge Clock);
            #1;
            t++;
        end while (!InReady && t < 200);
        if (!InReady) begin
            check("accept_timeout", 0, 1);
            return;
        end
        DataIn  = v;
        InValid = 1'b1;
        @(posedge Clock);
        if (push) exp_q.push_back(model(v));
        if (chk_period) check("period_ge9", int'(($time - last_acc_t) >= 90), 1);
        last_acc_t = $time;
        #1;
        InValid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(posedge Clock);
            t++;
        end
        repeat (2) @(posedge Clock);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    initial begin : stim
        logic [7:0] dir_vals[6];
        int k;
        int ov_seen;
        dir_vals = '{8'hFB, 8'hFF, 8'h81, 8'h7F, 8'h80, 8'h00};

        repeat (2) @(posedge Clock);
        #1;
        check("rst_inready", int'(InReady), 1);
        check("rst_outvalid", int'(OutValid), 0);
        check("rst_dataout", int'(DataOut), 0);
        check("rst_ovf", int'(Ovf), 0);
        Reset = 1'b0;

        rdy_mode = 1;
        send(8'h05, 1'b1);
        k = 0;
        while (!OutValid && k < 50) begin
            @(posedge Clock);
            #1;
            k++;
        end
        check("latency", k, 7);
        check("inready_in_done", int'(InReady), 0);
        @(posedge Clock);
        #1;
        check("inready_after", int'(InReady), 1);
        check("outvalid_after", int'(OutValid), 0);

        foreach (dir_vals[i]) send(dir_vals[i], 1'b1);
        drain(100);

        rdy_mode = 0;
        send(8'hFB, 1'b1);
        k = 0;
        while (!OutValid && k < 50) begin
            @(posedge Clock);
            #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            #1;
            check("hold_outvalid", int'(OutValid), 1);
            check("hold_data", int'(DataOut), 8'h85);
            check("hold_inready", int'(InReady), 0);
            DataIn  = 8'h11;
            InValid = 1'b1;
        end
        InValid  = 1'b0;
        rdy_mode = 1;
        drain(50);
        ov_seen = 0;
        repeat (12) begin
            @(posedge Clock);
            #1;
            if (OutValid) ov_seen++;
        end
        check("hold_no_extra", ov_seen, 0);

        send(8'h55, 1'b0);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        check("midrst_inready", int'(InReady), 1);
        check("midrst_outvalid", int'(OutValid), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        ov_seen = 0;
        repeat (15) begin
            @(posedge Clock);
            #1;
            if (OutValid) ov_seen++;
        end
        check("midrst_no_output", ov_seen, 0);
        send(8'h00, 1'b1);
        drain(50);

        rdy_mode = 2;
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom), 1'b1);
            chk_period = 1'b1;
        end
        chk_period = 1'b0;
        drain(2000);
        rdy_mode = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
